// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit with memory wait states.
// Opcode/funct constants, datapath select codes, instruction classes and state encoding.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [3:0] ALU_ADDU  = 4'h0;
    localparam logic [3:0] ALU_SUBU  = 4'h1;
    localparam logic [3:0] ALU_OR    = 4'h2;
    localparam logic [3:0] ALU_PASSB = 4'h3;
    localparam logic [3:0] ALU_ADD   = 4'h5;
    localparam logic [3:0] ALU_SLT   = 4'h6;
    localparam logic [3:0] ALU_INV   = 4'hF;

    localparam logic [2:0] NPC_PC4 = 3'b000;
    localparam logic [2:0] NPC_BR  = 3'b001;
    localparam logic [2:0] NPC_J   = 3'b010;
    localparam logic [2:0] NPC_REG = 3'b100;

    localparam logic [1:0] WD_ALU  = 2'b00;
    localparam logic [1:0] WD_MEM  = 2'b01;
    localparam logic [1:0] WD_LINK = 2'b10;
    localparam logic [1:0] WD_INV  = 2'b11;

    localparam logic [1:0] GPR_RT = 2'b00;
    localparam logic [1:0] GPR_RD = 2'b01;
    localparam logic [1:0] GPR_RA = 2'b10;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;
    localparam logic [1:0] EXT_INV  = 2'b11;

    // One-hot instruction class bit positions
    localparam int unsigned C_ALU  = 0;
    localparam int unsigned C_LD   = 1;
    localparam int unsigned C_ST   = 2;
    localparam int unsigned C_BEQ  = 3;
    localparam int unsigned C_BNE  = 4;
    localparam int unsigned C_J    = 5;
    localparam int unsigned C_JAL  = 6;
    localparam int unsigned C_JR   = 7;
    localparam int unsigned C_JALR = 8;
    localparam int unsigned C_ILL  = 9;
    localparam int unsigned N_CLS  = 10;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_DCD   = 3'd1,
        S_EXE   = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4
    } state_e;

endpackage

// File: rtl/mc_ctrl_wait_decode.sv
// Combinational instruction decoder: opcode/funct to one-hot class and
// the per-instruction static datapath fields.
module mc_ctrl_wait_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]       opcode_i,
    input  logic [5:0]       funct_i,
    output logic [N_CLS-1:0] cls_o,
    output logic [3:0]       alu_op_o,
    output logic             alu_bsel_o,
    output logic [1:0]       ext_op_o,
    output logic             bmode_o,
    output logic [1:0]       gpr_sel_o
);

    always_comb begin
        cls_o      = '0;
        alu_op_o   = ALU_ADDU;
        alu_bsel_o = 1'b0;
        ext_op_o   = EXT_ZERO;
        bmode_o    = 1'b0;
        gpr_sel_o  = GPR_RT;
        case (opcode_i)
            OP_RTYPE: begin
                gpr_sel_o = GPR_RD;
                case (funct_i)
                    FN_ADDU: cls_o[C_ALU] = 1'b1;
                    FN_SUBU: begin
                        cls_o[C_ALU] = 1'b1;
                        alu_op_o     = ALU_SUBU;
                    end
                    FN_SLT: begin
                        cls_o[C_ALU] = 1'b1;
                        alu_op_o     = ALU_SLT;
                    end
                    FN_JR:   cls_o[C_JR]   = 1'b1;
                    FN_JALR: cls_o[C_JALR] = 1'b1;
                    default: cls_o[C_ILL]  = 1'b1;
                endcase
            end
            OP_ORI: begin
                cls_o[C_ALU] = 1'b1;
                alu_op_o     = ALU_OR;
                alu_bsel_o   = 1'b1;
            end
            OP_LUI: begin
                cls_o[C_ALU] = 1'b1;
                alu_op_o     = ALU_PASSB;
                alu_bsel_o   = 1'b1;
                ext_op_o     = EXT_LUI;
            end
            OP_ADDI: begin
                cls_o[C_ALU] = 1'b1;
                alu_op_o     = ALU_ADD;
                alu_bsel_o   = 1'b1;
                ext_op_o     = EXT_SIGN;
            end
            OP_ADDIU: begin
                cls_o[C_ALU] = 1'b1;
                alu_bsel_o   = 1'b1;
                ext_op_o     = EXT_SIGN;
            end
            OP_LW, OP_LB: begin
                cls_o[C_LD] = 1'b1;
                alu_bsel_o  = 1'b1;
                ext_op_o    = EXT_SIGN;
                bmode_o     = (opcode_i == OP_LB);
            end
            OP_SW, OP_SB: begin
                cls_o[C_ST] = 1'b1;
                alu_bsel_o  = 1'b1;
                ext_op_o    = EXT_SIGN;
                bmode_o     = (opcode_i == OP_SB);
            end
            OP_BEQ: begin
                cls_o[C_BEQ] = 1'b1;
                alu_op_o     = ALU_SUBU;
                ext_op_o     = EXT_SIGN;
            end
            OP_BNE: begin
                cls_o[C_BNE] = 1'b1;
                alu_op_o     = ALU_SUBU;
                ext_op_o     = EXT_SIGN;
            end
            OP_J:   cls_o[C_J] = 1'b1;
            OP_JAL: begin
                cls_o[C_JAL] = 1'b1;
                gpr_sel_o    = GPR_RA;
            end
            default: cls_o[C_ILL] = 1'b1;
        endcase
        if (cls_o[C_ILL]) begin
            alu_op_o  = ALU_INV;
            ext_op_o  = EXT_INV;
            gpr_sel_o = GPR_RT;
        end
    end

endmodule

// File: rtl/mc_ctrl_wait.sv
// Multicycle MIPS control FSM with fetch/data wait states.
// MC_CTRL_RETIRE_CNT_EN adds the retire_cnt instruction counter output.
module mc_ctrl_wait
    import mc_ctrl_pkg::*;
#(
    parameter int IMEM_LAT = 0,
    parameter int DMEM_LAT = 0
`ifdef MC_CTRL_RETIRE_CNT_EN
    ,
    parameter int CNT_W    = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_wr,
    output logic [2:0]       npc_sel,
    output logic             ir_wr,
    output logic             gpr_wr,
    output logic [1:0]       gpr_sel,
    output logic [1:0]       wd_sel,
    output logic             dm_rd,
    output logic             dm_wr,
    output logic [3:0]       alu_op,
    output logic             alu_bsel,
    output logic [1:0]       ext_op,
    output logic             bmode,
    output logic             illegal,
    output logic             busy
`ifdef MC_CTRL_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] retire_cnt
`endif
);

    localparam logic [3:0] IMEM_L = 4'(IMEM_LAT);
    localparam logic [3:0] DMEM_L = 4'(DMEM_LAT);

    logic [N_CLS-1:0] cls;
    logic [3:0]       d_alu_op;
    logic             d_bsel;
    logic [1:0]       d_ext;
    logic             d_bmode;
    logic [1:0]       d_gsel;

    mc_ctrl_wait_decode u_dec (
        .opcode_i   (opcode),
        .funct_i    (funct),
        .cls_o      (cls),
        .alu_op_o   (d_alu_op),
        .alu_bsel_o (d_bsel),
        .ext_op_o   (d_ext),
        .bmode_o    (d_bmode),
        .gpr_sel_o  (d_gsel)
    );

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       wait_done;

    assign wait_done = (cnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = wait_done ? cnt_q : cnt_q - 4'd1;
        case (state_q)
            S_FETCH: if (wait_done) state_d = S_DCD;
            S_DCD:   state_d = S_EXE;
            S_EXE: begin
                if (cls[C_ALU]) begin
                    state_d = S_WB;
                end else if (cls[C_LD] || cls[C_ST]) begin
                    state_d = S_MEM;
                    cnt_d   = DMEM_L;
                end else begin
                    state_d = S_FETCH;
                    cnt_d   = IMEM_L;
                end
            end
            S_MEM: begin
                if (wait_done) begin
                    if (cls[C_LD]) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                        cnt_d   = IMEM_L;
                    end
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                cnt_d   = IMEM_L;
            end
            default: begin
                state_d = S_FETCH;
                cnt_d   = IMEM_L;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            cnt_q   <= IMEM_L;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are gated by rst so nothing can strobe while held in reset
    always_comb begin
        pc_wr    = 1'b0;
        npc_sel  = NPC_PC4;
        ir_wr    = 1'b0;
        gpr_wr   = 1'b0;
        gpr_sel  = GPR_RT;
        wd_sel   = WD_ALU;
        dm_rd    = 1'b0;
        dm_wr    = 1'b0;
        alu_op   = ALU_ADDU;
        alu_bsel = 1'b0;
        ext_op   = EXT_ZERO;
        bmode    = 1'b0;
        illegal  = 1'b0;
        busy     = 1'b0;
        if (rst) begin
            busy = 1'b1;
            if (state_q != S_FETCH) begin
                alu_op   = d_alu_op;
                alu_bsel = d_bsel;
                ext_op   = d_ext;
            end
            case (state_q)
                S_FETCH: begin
                    pc_wr  = wait_done;
                    ir_wr  = wait_done;
                    busy   = !wait_done;
                    alu_op = ALU_INV;
                    ext_op = EXT_INV;
                    wd_sel = WD_INV;
                end
                S_DCD: begin
                    if (cls[C_BEQ] || cls[C_BNE] || cls[C_J] || cls[C_JAL])
                        npc_sel = NPC_BR;
                end
                S_EXE: begin
                    illegal = cls[C_ILL];
                    unique case (1'b1)
                        cls[C_BEQ]: begin
                            pc_wr   = zero;
                            npc_sel = NPC_BR;
                        end
                        cls[C_BNE]: begin
                            pc_wr   = !zero;
                            npc_sel = NPC_BR;
                        end
                        cls[C_J]: begin
                            pc_wr   = 1'b1;
                            npc_sel = NPC_J;
                        end
                        cls[C_JAL]: begin
                            pc_wr   = 1'b1;
                            npc_sel = NPC_J;
                            gpr_wr  = 1'b1;
                            gpr_sel = d_gsel;
                            wd_sel  = WD_LINK;
                        end
                        cls[C_JR]: begin
                            pc_wr   = 1'b1;
                            npc_sel = NPC_REG;
                        end
                        cls[C_JALR]: begin
                            pc_wr   = 1'b1;
                            npc_sel = NPC_REG;
                            gpr_wr  = 1'b1;
                            gpr_sel = d_gsel;
                            wd_sel  = WD_LINK;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    dm_rd = cls[C_LD];
                    dm_wr = cls[C_ST] && wait_done;
                    bmode = d_bmode;
                end
                S_WB: begin
                    gpr_wr  = 1'b1;
                    gpr_sel = d_gsel;
                    wd_sel  = cls[C_LD] ? WD_MEM : WD_ALU;
                end
                default: ;
            endcase
        end
    end

`ifdef MC_CTRL_RETIRE_CNT_EN
    logic             last_cyc;
    logic [CNT_W-1:0] ret_q;

    assign last_cyc   = (state_q != S_FETCH) && (state_d == S_FETCH);
    assign retire_cnt = ret_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ret_q <= '0;
        else if (last_cyc) ret_q <= ret_q + 1'b1;
    end
`endif

endmodule

// File: tb/tb_mc_ctrl_wait.sv
// Scoreboard bench for mc_ctrl_wait: per-cycle expected output bundles
// are queued per instruction and compared as the FSM steps.
module tb_mc_ctrl_wait;

    localparam int L = 2;
    localparam int D = 3;

    typedef struct packed {
        logic       pc_wr;
        logic [2:0] npc_sel;
        logic       ir_wr;
        logic       gpr_wr;
        logic [1:0] gpr_sel;
        logic [1:0] wd_sel;
        logic       dm_rd;
        logic       dm_wr;
        logic [3:0] alu_op;
        logic       alu_bsel;
        logic [1:0] ext_op;
        logic       bmode;
        logic       illegal;
        logic       busy;
    } ov_t;

    typedef enum {K_ALUR, K_ALUI, K_LD, K_ST, K_BR,
                  K_J, K_JAL, K_JR, K_JALR, K_ILL} kind_e;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       pc_wr, ir_wr, gpr_wr, dm_rd, dm_wr;
    logic       alu_bsel, bmode, illegal, busy;
    logic [2:0] npc_sel;
    logic [1:0] gpr_sel, wd_sel, ext_op;
    logic [3:0] alu_op;
`ifdef MC_CTRL_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
    logic [31:0] exp_ret = '0;
`endif

    ov_t act;
    assign act = {pc_wr, npc_sel, ir_wr, gpr_wr, gpr_sel, wd_sel,
                  dm_rd, dm_wr, alu_op, alu_bsel, ext_op, bmode,
                  illegal, busy};

    mc_ctrl_wait #(.IMEM_LAT(L), .DMEM_LAT(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .funct    (funct),
        .zero     (zero),
        .pc_wr    (pc_wr),
        .npc_sel  (npc_sel),
        .ir_wr    (ir_wr),
        .gpr_wr   (gpr_wr),
        .gpr_sel  (gpr_sel),
        .wd_sel   (wd_sel),
        .dm_rd    (dm_rd),
        .dm_wr    (dm_wr),
        .alu_op   (alu_op),
        .alu_bsel (alu_bsel),
        .ext_op   (ext_op),
        .bmode    (bmode),
        .illegal  (illegal),
        .busy     (busy)
`ifdef MC_CTRL_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    ov_t   q_exp[$];
    ov_t   q_msk[$];
    string q_tag[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic push(input string tag, input ov_t e, input ov_t m);
        q_exp.push_back(e);
        q_msk.push_back(m);
        q_tag.push_back(tag);
    endtask

    task automatic ref_dec(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, output kind_e k,
                           output logic [3:0] alu, output logic [1:0] ext,
                           output logic bm, output logic take);
        k = K_ILL; alu = 4'h0; ext = 2'b00; bm = 1'b0; take = 1'b0;
        case (op)
            6'h00: case (fn)
                6'h21: k = K_ALUR;
                6'h23: begin k = K_ALUR; alu = 4'h1; end
                6'h2A: begin k = K_ALUR; alu = 4'h6; end
                6'h08: k = K_JR;
                6'h09: k = K_JALR;
                default: k = K_ILL;
            endcase
            6'h0D: begin k = K_ALUI; alu = 4'h2; ext = 2'b00; end
            6'h0F: begin k = K_ALUI; alu = 4'h3; ext = 2'b10; end
            6'h08: begin k = K_ALUI; alu = 4'h5; ext = 2'b01; end
            6'h09: begin k = K_ALUI; alu = 4'h0; ext = 2'b01; end
            6'h23: begin k = K_LD; ext = 2'b01; end
            6'h20: begin k = K_LD; ext = 2'b01; bm = 1'b1; end
            6'h2B: begin k = K_ST; ext = 2'b01; end
            6'h28: begin k = K_ST; ext = 2'b01; bm = 1'b1; end
            6'h04: begin k = K_BR; alu = 4'h1; take = z; end
            6'h05: begin k = K_BR; alu = 4'h1; take = !z; end
            6'h02: k = K_J;
            6'h03: k = K_JAL;
            default: k = K_ILL;
        endcase
    endtask

    task automatic push_instr(input string nm, input logic [5:0] op,
                              input logic [5:0] fn, input logic z);
        kind_e k;
        logic [3:0] alu;
        logic [1:0] ext;
        logic bm, take;
        ov_t e, m, core;
        ref_dec(op, fn, z, k, alu, ext, bm, take);
        core = '0;
        core.pc_wr = 1'b1; core.ir_wr = 1'b1; core.gpr_wr = 1'b1;
        core.dm_rd = 1'b1; core.dm_wr = 1'b1;
        core.illegal = 1'b1; core.busy = 1'b1;
        for (int i = 0; i <= L; i++) begin
            e = '0;
            e.alu_op = 4'hF; e.ext_op = 2'b11; e.wd_sel = 2'b11;
            e.pc_wr = (i == L); e.ir_wr = (i == L); e.busy = (i != L);
            push($sformatf("%s/fetch%0d", nm, i), e, '1);
        end
        e = '0; e.busy = 1'b1;
        if (k == K_BR || k == K_J || k == K_JAL) e.npc_sel = 3'b001;
        m = core; m.npc_sel = '1;
        push($sformatf("%s/dcd", nm), e, m);
        e = '0; e.busy = 1'b1; m = core;
        e.illegal = (k == K_ILL);
        case (k)
            K_BR:   begin e.pc_wr = take; e.npc_sel = 3'b001; end
            K_J:    begin e.pc_wr = 1'b1; e.npc_sel = 3'b010; end
            K_JAL:  begin e.pc_wr = 1'b1; e.npc_sel = 3'b010;
                          e.gpr_wr = 1'b1; e.gpr_sel = 2'b10; e.wd_sel = 2'b10; end
            K_JR:   begin e.pc_wr = 1'b1; e.npc_sel = 3'b100; end
            K_JALR: begin e.pc_wr = 1'b1; e.npc_sel = 3'b100;
                          e.gpr_wr = 1'b1; e.gpr_sel = 2'b01; e.wd_sel = 2'b10; end
            default: ;
        endcase
        if (k inside {K_BR, K_J, K_JAL, K_JR, K_JALR}) m.npc_sel = '1;
        if (e.gpr_wr) begin m.gpr_sel = '1; m.wd_sel = '1; end
        if (k inside {K_ALUR, K_ALUI, K_LD, K_ST, K_BR}) begin
            e.alu_op = alu; m.alu_op = '1;
        end
        if (k inside {K_ALUR, K_ALUI, K_LD, K_ST}) begin
            e.alu_bsel = (k != K_ALUR); m.alu_bsel = 1'b1;
        end
        if (k inside {K_ALUI, K_LD, K_ST}) begin
            e.ext_op = ext; m.ext_op = '1;
        end
        push($sformatf("%s/exe", nm), e, m);
        if (k == K_LD || k == K_ST) begin
            for (int j = 0; j <= D; j++) begin
                e = '0; e.busy = 1'b1;
                e.dm_rd = (k == K_LD);
                e.dm_wr = (k == K_ST) && (j == D);
                e.bmode = bm;
                m = core; m.bmode = 1'b1;
                push($sformatf("%s/mem%0d", nm, j), e, m);
            end
        end
        if (k == K_ALUR || k == K_ALUI || k == K_LD) begin
            e = '0; e.busy = 1'b1; e.gpr_wr = 1'b1;
            e.wd_sel = (k == K_LD) ? 2'b01 : 2'b00;
            e.gpr_sel = (k == K_ALUR) ? 2'b01 : 2'b00;
            m = core; m.wd_sel = '1; m.gpr_sel = '1;
            push($sformatf("%s/wb", nm), e, m);
        end
    endtask

    task automatic drain(input int n);
        ov_t e, m;
        string t;
        for (int i = 0; i < n && q_exp.size() > 0; i++) begin
            @(negedge clk);
            e = q_exp.pop_front();
            m = q_msk.pop_front();
            t = q_tag.pop_front();
            chk(t, 32'(act & m), 32'(e & m));
        end
    endtask

    task automatic run(input string nm, input logic [5:0] op,
                       input logic [5:0] fn, input logic z);
        opcode = op; funct = fn; zero = z;
        push_instr(nm, op, fn, z);
        drain(q_exp.size());
        @(posedge clk);
        #1;
`ifdef MC_CTRL_RETIRE_CNT_EN
        exp_ret++;
        chk({nm, "/retire"}, retire_cnt, exp_ret);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_outs", 32'(act), 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        run("addu",  6'h00, 6'h21, 1'b0);
        run("lw",    6'h23, 6'h00, 1'b0);
        run("subu",  6'h00, 6'h23, 1'b1);
        run("slt",   6'h00, 6'h2A, 1'b0);
        run("ori",   6'h0D, 6'h00, 1'b0);
        run("lui",   6'h0F, 6'h00, 1'b0);
        run("addi",  6'h08, 6'h00, 1'b0);
        run("addiu", 6'h09, 6'h00, 1'b0);
        run("lb",    6'h20, 6'h00, 1'b0);
        run("sw",    6'h2B, 6'h00, 1'b0);
        run("sb",    6'h28, 6'h00, 1'b0);
        run("beq_t", 6'h04, 6'h00, 1'b1);
        run("beq_n", 6'h04, 6'h00, 1'b0);
        run("bne_n", 6'h05, 6'h00, 1'b1);
        run("bne_t", 6'h05, 6'h00, 1'b0);
        run("j",     6'h02, 6'h00, 1'b0);
        run("jal",   6'h03, 6'h00, 1'b0);
        run("jr",    6'h00, 6'h08, 1'b0);
        run("jalr",  6'h00, 6'h09, 1'b0);
        run("ill3f", 6'h3F, 6'h00, 1'b0);
        run("illfn", 6'h00, 6'h00, 1'b0);
        run("addu2", 6'h00, 6'h21, 1'b0);
        // store aborted by reset in its second MEM cycle
        opcode = 6'h2B; funct = 6'h00; zero = 1'b0;
        push_instr("sw_abort", 6'h2B, 6'h00, 1'b0);
        drain(L + 1 + 2 + 1);
        @(posedge clk);
        #1 rst = 1'b0;
        q_exp.delete(); q_msk.delete(); q_tag.delete();
        #1 chk("abort_outs", 32'(act), 32'h0);
        @(negedge clk);
        chk("abort_hold", 32'(act), 32'h0);
`ifdef MC_CTRL_RETIRE_CNT_EN
        exp_ret = '0;
        chk("abort_retire", retire_cnt, exp_ret);
`endif
        @(posedge clk);
        #1 rst = 1'b1;
        run("restart", 6'h00, 6'h21, 1'b0);
        run("ill_re",  6'h3F, 6'h00, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
